// File: rtl/hqc_params_pkg.sv
// Shared HQC parameter helpers, load-port type codes and loader state encoding.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package hqc_params_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_U,
        ST_FLUSH_U,
        ST_LOAD_V,
        ST_LOAD_D,
        ST_START,
        ST_WAIT
    } ld_state_t;

    localparam logic [1:0] TYPE_IDLE = 2'd0;
    localparam logic [1:0] TYPE_D    = 2'd1;
    localparam logic [1:0] TYPE_U    = 2'd2;
    localparam logic [1:0] TYPE_V    = 2'd3;

    localparam int D_WORDS = 16;

    // set_idx: 0 = hqc128, 1 = hqc192, 2 = hqc256
    function automatic int hqc_n(input int set_idx);
        case (set_idx)
            2:       return 57637;
            1:       return 35851;
            default: return 17669;
        endcase
    endfunction

    function automatic int hqc_n1n2(input int set_idx);
        case (set_idx)
            2:       return 57600;
            1:       return 35840;
            default: return 17664;
        endcase
    endfunction

    function automatic int hqc_ramdepth(input int n, input int ramwidth);
        return (n + (ramwidth - n % ramwidth) % ramwidth) / ramwidth;
    endfunction

endpackage

// File: rtl/ct_loader_word_packer.sv
// Packs 32-bit words into RAMWIDTH-bit rows; emits a row on the top lane or on flush.
module word_packer
    import hqc_params_pkg::*;
#(
    parameter int RAMWIDTH  = 256,
    parameter int LAST_BITS = 5,
    localparam int LANES    = RAMWIDTH / 32,
    localparam int LANE_W   = `CLOG2(LANES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                word_valid,
    input  logic [LANE_W-1:0]   word_lane,
    input  logic [31:0]         word_data,
    input  logic                word_last,
    input  logic                flush,
    output logic                row_valid,
    output logic [RAMWIDTH-1:0] row_data
);

    localparam logic [31:0] LAST_MASK = (LAST_BITS == 0) ? 32'hFFFF_FFFF
                                                         : ((32'd1 << LAST_BITS) - 32'd1);

    logic [RAMWIDTH-1:0] pack_q;
    logic [31:0]         word_m;

    always_comb begin
        word_m    = word_last ? (word_data & LAST_MASK) : word_data;
        row_data  = pack_q;
        if (word_valid) begin
            row_data[{word_lane, 5'b00000} +: 32] = word_m;
        end
        row_valid = flush || (word_valid && (word_lane == LANE_W'(LANES - 1)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pack_q <= '0;
        end else if (clear || row_valid) begin
            pack_q <= '0;
        end else if (word_valid) begin
            pack_q <= row_data;
        end
    end

endmodule

// File: rtl/ct_loader.sv
// Ciphertext loader: streams u, v and d words into the decap load port, then starts decap.
//
//  state      | meaning
//  -----------+--------------------------------------------------
//  ST_IDLE    | waiting for load_start, s_ready low
//  ST_LOAD_U  | packing u words into rows, writing full rows
//  ST_FLUSH_U | writing the partial last u row at RAMDEPTH-1
//  ST_LOAD_V  | packing v words, V_ROWS full rows
//  ST_LOAD_D  | writing d words one per accepted word
//  ST_START   | one cycle before the decap_start pulse
//  ST_WAIT    | waiting for decap_done
module ct_loader
    import hqc_params_pkg::*;
#(
    parameter        parameter_set = "hqc128",
    parameter int    RAMWIDTH      = 256,
    localparam int   SET_IDX       = (parameter_set == "hqc256") ? 2 :
                                     ((parameter_set == "hqc192") ? 1 : 0),
    localparam int   N             = hqc_n(SET_IDX),
    localparam int   N1N2          = hqc_n1n2(SET_IDX),
    localparam int   RAMDEPTH      = hqc_ramdepth(N, RAMWIDTH),
    localparam int   LOG_RAMDEPTH  = `CLOG2(RAMDEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_start,
    input  logic                    s_valid,
    input  logic [31:0]             s_data,
    output logic                    s_ready,
    output logic [1:0]              decap_in_type,
    output logic [RAMWIDTH-1:0]     decap_in,
    output logic [LOG_RAMDEPTH-1:0] decap_in_addr,
    output logic                    decap_in_wen,
    output logic                    decap_start,
    input  logic                    decap_done,
    output logic                    busy,
    output logic                    done
);

    localparam int LANES   = RAMWIDTH / 32;
    localparam int LANE_W  = `CLOG2(LANES);
    localparam int U_WORDS = (N + 31) / 32;
    localparam int V_ROWS  = N1N2 / RAMWIDTH;
    localparam int WCNT_W  = `CLOG2(U_WORDS + 1);

    ld_state_t            state_q, state_d;
    logic [WCNT_W-1:0]    word_cnt_q;
    logic [LANE_W-1:0]    lane_q;
    logic [LOG_RAMDEPTH-1:0] row_q;
    logic                 accept, lane_last, u_last, flush, pack_word;
    logic                 row_valid;
    logic [RAMWIDTH-1:0]  row_data;

    assign lane_last = (lane_q == LANE_W'(LANES - 1));
    assign accept    = s_valid && s_ready;
    assign u_last    = (state_q == ST_LOAD_U) && (word_cnt_q == WCNT_W'(U_WORDS - 1));
    assign pack_word = accept && ((state_q == ST_LOAD_U) || (state_q == ST_LOAD_V));

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        flush   = 1'b0;
        case (state_q)
            ST_IDLE:    if (load_start) state_d = ST_LOAD_U;
            ST_LOAD_U: begin
                s_ready = 1'b1;
                if (s_valid && u_last) state_d = ST_FLUSH_U;
            end
            ST_FLUSH_U: begin
                flush   = 1'b1;
                state_d = ST_LOAD_V;
            end
            ST_LOAD_V: begin
                s_ready = 1'b1;
                if (s_valid && lane_last && (row_q == LOG_RAMDEPTH'(V_ROWS - 1)))
                    state_d = ST_LOAD_D;
            end
            ST_LOAD_D: begin
                s_ready = 1'b1;
                if (s_valid && (word_cnt_q == WCNT_W'(D_WORDS - 1))) state_d = ST_START;
            end
            ST_START:   state_d = ST_WAIT;
            ST_WAIT:    if (decap_done) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every phase change starts its counters from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt_q <= '0;
            lane_q     <= '0;
            row_q      <= '0;
        end else if (state_d != state_q) begin
            word_cnt_q <= '0;
            lane_q     <= '0;
            row_q      <= '0;
        end else if (accept) begin
            word_cnt_q <= word_cnt_q + 1'b1;
            lane_q     <= lane_last ? '0 : lane_q + 1'b1;
            if (lane_last) row_q <= row_q + 1'b1;
        end
    end

    word_packer #(
        .RAMWIDTH  (RAMWIDTH),
        .LAST_BITS (N % 32)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_q == ST_IDLE),
        .word_valid (pack_word),
        .word_lane  (lane_q),
        .word_data  (s_data),
        .word_last  (u_last),
        .flush      (flush),
        .row_valid  (row_valid),
        .row_data   (row_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            decap_in_wen  <= 1'b0;
            decap_in_type <= TYPE_IDLE;
            decap_in_addr <= '0;
            decap_in      <= '0;
            decap_start   <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            decap_in_wen <= 1'b0;
            if (row_valid) begin
                decap_in_wen  <= 1'b1;
                decap_in      <= row_data;
                decap_in_addr <= flush ? LOG_RAMDEPTH'(RAMDEPTH - 1) : row_q;
                decap_in_type <= (state_q == ST_LOAD_V) ? TYPE_V : TYPE_U;
            end else if (accept && (state_q == ST_LOAD_D)) begin
                decap_in_wen  <= 1'b1;
                decap_in      <= {{(RAMWIDTH - 32){1'b0}}, s_data};
                decap_in_addr <= LOG_RAMDEPTH'(word_cnt_q);
                decap_in_type <= TYPE_D;
            end else if (state_d == ST_IDLE) begin
                decap_in_type <= TYPE_IDLE;
            end
            decap_start <= (state_q == ST_START);
            done        <= (state_q == ST_WAIT) && decap_done;
            busy        <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_ct_loader.sv
// Scoreboard bench for ct_loader: hqc128 and hqc256 instances share one stream driver.
module tb_ct_loader;

    typedef struct packed {
        logic [1:0]   t;
        logic [7:0]   a;
        logic [255:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sel = 1'b0;
    logic load_start = 1'b0;
    logic s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic dd = 1'b0;

    logic         sr128, wen128, st128, done128, busy128;
    logic [1:0]   ty128;
    logic [255:0] dat128;
    logic [6:0]   ad128;
    logic         sr256, wen256, st256, done256, busy256;
    logic [1:0]   ty256;
    logic [255:0] dat256;
    logic [7:0]   ad256;

    logic         s_ready_m, wen_m, start_m, done_m, busy_m;
    logic [1:0]   type_m;
    logic [7:0]   addr_m;
    logic [255:0] data_m;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   starts_seen = 0;
    logic start_pend = 1'b0;

    always #5 clk = ~clk;

    ct_loader #(.parameter_set("hqc128"), .RAMWIDTH(256)) dut128 (
        .clk(clk), .rst(rst), .load_start(load_start && !sel),
        .s_valid(s_valid && !sel), .s_data(s_data), .s_ready(sr128),
        .decap_in_type(ty128), .decap_in(dat128), .decap_in_addr(ad128),
        .decap_in_wen(wen128), .decap_start(st128), .decap_done(dd && !sel),
        .busy(busy128), .done(done128)
    );

    ct_loader #(.parameter_set("hqc256"), .RAMWIDTH(256)) dut256 (
        .clk(clk), .rst(rst), .load_start(load_start && sel),
        .s_valid(s_valid && sel), .s_data(s_data), .s_ready(sr256),
        .decap_in_type(ty256), .decap_in(dat256), .decap_in_addr(ad256),
        .decap_in_wen(wen256), .decap_start(st256), .decap_done(dd && sel),
        .busy(busy256), .done(done256)
    );

    assign s_ready_m = sel ? sr256   : sr128;
    assign wen_m     = sel ? wen256  : wen128;
    assign start_m   = sel ? st256   : st128;
    assign done_m    = sel ? done256 : done128;
    assign busy_m    = sel ? busy256 : busy128;
    assign type_m    = sel ? ty256   : ty128;
    assign addr_m    = sel ? ad256   : {1'b0, ad128};
    assign data_m    = sel ? dat256  : dat128;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] t, input int a, input logic [255:0] d);
        exp_t e;
        e.t = t;
        e.a = 8'(a);
        e.d = d;
        q.push_back(e);
    endtask

    // Scoreboard pop on every write strobe; decap_start must follow the d word 15 write.
    always @(negedge clk) begin
        exp_t e;
        if (wen_m) begin
            if (q.size() == 0) begin
                chk("unexpected_wen", wen_m, 1'b0);
            end else begin
                e = q.pop_front();
                chk("wen_type", type_m, e.t);
                chk("wen_addr", addr_m, e.a);
                chk("wen_data", data_m, e.d);
            end
        end
        if (start_m || start_pend) begin
            chk("start_timing", start_m, start_pend);
            if (start_m) starts_seen++;
        end
        start_pend = wen_m && (type_m == 2'd1) && (addr_m == 8'd15);
    end

    task automatic send_word(input logic [31:0] w, input bit gap);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = s_ready_m;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("ready_timeout", s_ready_m, 1'b1);
        s_valid = 1'b0;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_load(input bit gap, input bit poke, input int abort_v, input bit ones_last);
        int uw, vw, depth, base, n;
        logic [255:0] row;
        logic [31:0] w, wm;
        uw    = sel ? 1802 : 553;
        vw    = sel ? 1800 : 552;
        depth = sel ? 226 : 70;
        base  = starts_seen;

        @(posedge clk); #1;
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        chk("busy_on", busy_m, 1'b1);

        row = '0;
        for (int i = 0; i < uw; i++) begin
            w  = $urandom;
            if (i == uw - 1 && ones_last) w = 32'hFFFF_FFFF;
            wm = (i == uw - 1) ? (w & 32'h0000_001F) : w;
            row[32 * (i % 8) +: 32] = wm;
            if (i % 8 == 7) begin
                push(2'd2, i / 8, row);
                row = '0;
            end
            send_word(w, gap);
        end
        push(2'd2, depth - 1, row);

        row = '0;
        for (int i = 0; i < vw; i++) begin
            if (i == abort_v) begin
                rst = 1'b0;
                #1;
                chk("abort_ctrl", {wen_m, type_m, addr_m, start_m, done_m, busy_m, s_ready_m}, '0);
                chk("abort_data", data_m, '0);
                chk("abort_pending", q.size(), 0);
                q.delete();
                repeat (3) @(posedge clk);
                #1;
                rst = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                chk("abort_idle_busy", busy_m, 1'b0);
                return;
            end
            w = $urandom;
            row[32 * (i % 8) +: 32] = w;
            if (i % 8 == 7) begin
                push(2'd3, i / 8, row);
                row = '0;
            end
            if (poke && i == 10) load_start = 1'b1;
            send_word(w, gap);
            load_start = 1'b0;
        end

        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            push(2'd1, i, {224'b0, w});
            if (poke && i == 5) dd = 1'b1;
            send_word(w, gap);
            if (poke && i == 5) begin
                dd = 1'b0;
                chk("done_ignored", done_m, 1'b0);
            end
        end

        n = 0;
        while (starts_seen == base && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("start_count", starts_seen - base, 1);
        chk("writes_left", q.size(), 0);
        chk("busy_in_wait", busy_m, 1'b1);
        chk("ready_in_wait", s_ready_m, 1'b0);

        dd = 1'b1;
        @(posedge clk); #1;
        dd = 1'b0;
        chk("done_pulse", done_m, 1'b1);
        chk("busy_off", busy_m, 1'b0);
        @(posedge clk); #1;
        chk("done_single", done_m, 1'b0);
        chk("type_idle", type_m, 2'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_128", {sr128, wen128, st128, done128, busy128, ty128, ad128, dat128 != 0}, '0);
        chk("rst_256", {sr256, wen256, st256, done256, busy256, ty256, ad256, dat256 != 0}, '0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ready", s_ready_m, 1'b0);

        run_load(1'b0, 1'b0, -1, 1'b1);
        run_load(1'b1, 1'b0, -1, 1'b0);
        run_load(1'b0, 1'b1, -1, 1'b1);
        run_load(1'b0, 1'b0, 100, 1'b0);
        run_load(1'b0, 1'b0, -1, 1'b1);

        @(posedge clk); #1;
        sel = 1'b1;
        run_load(1'b0, 1'b0, -1, 1'b1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ct_loader.md
Name: ct_loader

Overview:
- Upstream feeder for the decap core: accepts the ciphertext (u, v) and the d hash as a 32-bit valid/ready word stream.
- Packs the u and v words into RAMWIDTH-bit rows and drives the decap_in_type/decap_in/decap_in_addr/decap_in_wen load port. Writes the 16 d words directly.
- Pulses decap start, then waits for decap done before accepting a new ciphertext.
- Replaces bench-driven loading in the system top.

Parameters:
- parameter_set, "hqc128", selects N and N1N2 ("hqc128"/"hqc192"/"hqc256").
- RAMWIDTH, 256, decap RAM row width; must be a multiple of 32.
- N, 17669/35851/57637, code length per set.
- N1N2, 17664/35840/57600, concatenated code length per set.
- RAMDEPTH, (N+(RAMWIDTH-N%RAMWIDTH)%RAMWIDTH)/RAMWIDTH, number of u rows.
- LOG_RAMDEPTH, CLOG2(RAMDEPTH), address width.
- U_WORDS, (N+31)/32, 32-bit u words accepted (553 for hqc128).
- V_WORDS, N1N2/32, 32-bit v words accepted (552 for hqc128).
- V_ROWS, N1N2/RAMWIDTH, v rows (69 for hqc128; equals RAMDEPTH-1 for all sets).
- D_WORDS, 16, d words.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- load_start  in  1  one-cycle request to begin a load; honoured only in IDLE.
- s_valid  in  1  input word valid.
- s_data  in  32  input word; u words first, then v, then d.
- s_ready  out  1  word accepted when s_valid&&s_ready.
- decap_in_type  out  2  2=u, 3=v, 1=d, 0=idle.
- decap_in  out  RAMWIDTH  write data; d words in bits [31:0], upper bits zero.
- decap_in_addr  out  LOG_RAMDEPTH  row or d-word address.
- decap_in_wen  out  1  one-cycle write strobe.
- decap_start  out  1  one-cycle start pulse to decap.
- decap_done  in  1  decap completion pulse.
- busy  out  1  high from accepted load_start until done.
- done  out  1  one-cycle pulse, registered from decap_done seen in WAIT.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, packing register 0. Reset asserted in any state returns to IDLE within the same edge; a partial load is discarded and no further wen or start is issued.
- FSM states: IDLE -> LOAD_U -> FLUSH_U -> LOAD_V -> LOAD_D -> START -> WAIT -> IDLE.
- IDLE: s_ready=0; s_valid is ignored. load_start -> LOAD_U with word counter, lane counter and row address all cleared.
- LOAD_U:
  - s_ready=1. Each accepted word goes into lane k of the packing register, bits [32k+31:32k], with k = word index mod 8 (RAMWIDTH=256).
  - On lane 7, the next cycle asserts decap_in_wen with type=2, addr=row, and the packed row. The row increments and the packing register clears.
  - The last u word (index U_WORDS-1) has bits >= N%32 forced to 0 (hqc128: only bits [4:0] kept). Then -> FLUSH_U.
- FLUSH_U:
  - s_ready=0. Writes the partial row, unused lanes zero, at addr RAMDEPTH-1.
  - U_WORDS is never a multiple of 8 for any set, so exactly one flush write occurs.
  - -> LOAD_V; counters clear.
- LOAD_V: same packing as LOAD_U, type=3, V_ROWS full rows, no partial row. After the write of row V_ROWS-1 -> LOAD_D.
- LOAD_D: s_ready=1. Each accepted word is written the next cycle: type=1, addr=index 0..15, decap_in={zeros, word}. After word 15's write -> START.
- START: decap_start=1 for exactly one cycle; -> WAIT.
- WAIT: s_ready=0. decap_done -> done pulse next cycle, busy drops with it, -> IDLE.
- Output timing: wen, type, addr and data are registered and mutually aligned, so the decap sees address and data in the same cycle as wen. type holds its value through a phase and returns to 0 in IDLE.
- Throughput: one word per cycle with s_valid held high. s_valid low simply stalls; no timeout.
- Simultaneous events:
  - load_start while busy is ignored.
  - decap_done outside WAIT is ignored.
  - s_valid coincident with a state change is not accepted, since s_ready is already 0 in FLUSH_U, START and WAIT.

Decomposition:
- Shared package hqc_params_pkg holds: parameter_set-derived N, N1N2, RAMDEPTH; the CLOG2 macro; decap_in_type codes (TYPE_D=1, TYPE_U=2, TYPE_V=3); the state enum.
- One natural sub-module, word_packer: 32-to-RAMWIDTH lane packer with a last-word bit mask and a flush input, producing row_valid/row_data. The FSM and counters stay in ct_loader.

Test Plan:
- hqc128, continuous s_valid, 1121 words -> 70 type-2 writes (addr 0..69), 69 type-3 writes (0..68), 16 type-1 writes (0..15), one decap_start the cycle after the last d write. Verify against u_128.in/v_128.in/d_128.in.
- u word 552 = 0xFFFFFFFF -> row 69 data = 0x1F in bits [4:0], all other bits 0.
- s_valid toggled 1-0 every cycle -> identical write sequence and data; s_ready only ever accepts when valid.
- load_start during LOAD_V, and decap_done pulsed during LOAD_D -> both ignored; no extra start, done stays 0.
- rst low at v word 100 -> all outputs 0 immediately, busy=0; a fresh full load afterwards completes correctly.
- hqc256 -> 226 u writes, 225 v writes; u row 225 has lanes 0-1 used (lane 1 bits >= 5 zero) and lanes 2-7 zero; done pulses one cycle after decap_done.
